dino_motion_controller: RTL and testbench

//  Frame-synchronous motion sequencer for the player dino sprite; drives the dino_x/dino_y inputs of the VGA controller.

---
 rtl/dino_motion_controller.sv | 172 +++++++++++++++++
 tb/tb_dino_motion_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dino_motion_controller.sv
// Frame-synchronous motion sequencer for the player dino sprite.
// Synchronises the up/down buttons, runs the GROUND/RISE/FALL/DUCK machine and
// updates the sprite position once per frame on the rising edge of screenEnd.
// Optional feature macro: DINO_FAST_FALL_EN (down while airborne forces a fast fall).
module dino_motion_controller #(
    parameter int unsigned GROUND_Y = 275,
    parameter int unsigned DINO_X   = 100,
    parameter int unsigned JUMP_VEL = 14,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic        up,
    input  logic        down,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        ducking,
    output logic        airborne,
    output logic [1:0]  state
);

    localparam logic [1:0] StGround = 2'd0;
    localparam logic [1:0] StRise   = 2'd1;
    localparam logic [1:0] StFall   = 2'd2;
    localparam logic [1:0] StDuck   = 2'd3;

    localparam logic [9:0] GroundY = 10'(GROUND_Y);
    localparam logic [4:0] JumpVel = 5'(JUMP_VEL);
    localparam logic [4:0] Gravity = 5'(GRAVITY);
    localparam logic [4:0] MaxFall = 5'(MAX_FALL);

    logic       up_meta, up_sync, up_prev;
    logic       down_meta, down_sync;
    logic       screen_prev;
    logic       jump_pending_q, jump_pending_d;
    logic [1:0] state_q, state_d;
    logic [9:0] y_q, y_d;
    logic [4:0] vel_q, vel_d;
    logic       ducking_q, airborne_q;

    logic       tick;
    logic       up_edge;
    logic [5:0] vel_inc;
    logic [4:0] fall_vel;
    logic [10:0] fall_sum;

    // Subtraction on the 10-bit row coordinate never wraps below row 0.
    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [4:0] b);
        if (a < {5'd0, b}) begin
            return 10'd0;
        end
        return a - {5'd0, b};
    endfunction

    assign tick    = screenEnd & ~screen_prev;
    assign up_edge = up_sync & ~up_prev;

    // An up edge landing on the tick cycle survives into the next frame.
    always_comb begin
        jump_pending_d = tick ? up_edge : (jump_pending_q | up_edge);
    end

    // Fall velocity for this tick, capped at the terminal speed.
    always_comb begin
        vel_inc = {1'b0, vel_q} + {1'b0, Gravity};
`ifdef DINO_FAST_FALL_EN
        if (down_sync) begin
            fall_vel = MaxFall;
        end else
`endif
        if (vel_inc > {1'b0, MaxFall}) begin
            fall_vel = MaxFall;
        end else begin
            fall_vel = vel_inc[4:0];
        end
        fall_sum = {1'b0, y_q} + {6'd0, fall_vel};
    end

    // Per-frame motion state machine; nothing moves between ticks.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        if (tick) begin
            unique case (state_q)
                StGround: begin
                    if (jump_pending_q) begin
                        state_d = StRise;
                        y_d     = sat_sub(GroundY, JumpVel);
                        vel_d   = JumpVel - Gravity;
                    end else if (down_sync) begin
                        state_d = StDuck;
                    end
                end
                StRise: begin
`ifdef DINO_FAST_FALL_EN
                    if (down_sync) begin
                        state_d = StFall;
                        vel_d   = MaxFall;
                    end else
`endif
                    begin
                        y_d = sat_sub(y_q, vel_q);
                        if (vel_q <= Gravity) begin
                            state_d = StFall;
                            vel_d   = 5'd0;
                        end else begin
                            vel_d = vel_q - Gravity;
                        end
                    end
                end
                StFall: begin
                    // Clamp the landing so the sprite never sinks below the ground row.
                    if (fall_sum >= {1'b0, GroundY}) begin
                        state_d = StGround;
                        y_d     = GroundY;
                        vel_d   = 5'd0;
                    end else begin
                        y_d   = fall_sum[9:0];
                        vel_d = fall_vel;
                    end
                end
                StDuck: begin
                    y_d = GroundY;
                    if (!down_sync) begin
                        state_d = StGround;
                    end
                end
            endcase
        end
    end

    // Button synchronisers, edge history and the registered motion state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_meta        <= 1'b0;
            up_sync        <= 1'b0;
            up_prev        <= 1'b0;
            down_meta      <= 1'b0;
            down_sync      <= 1'b0;
            screen_prev    <= 1'b0;
            jump_pending_q <= 1'b0;
            state_q        <= StGround;
            y_q            <= GroundY;
            vel_q          <= 5'd0;
            ducking_q      <= 1'b0;
            airborne_q     <= 1'b0;
        end else begin
            up_meta        <= up;
            up_sync        <= up_meta;
            up_prev        <= up_sync;
            down_meta      <= down;
            down_sync      <= down_meta;
            screen_prev    <= screenEnd;
            jump_pending_q <= jump_pending_d;
            state_q        <= state_d;
            y_q            <= y_d;
            vel_q          <= vel_d;
            ducking_q      <= (state_d == StDuck);
            airborne_q     <= (state_d == StRise) || (state_d == StFall);
        end
    end

    assign dino_x   = 32'(DINO_X);
    assign dino_y   = {22'd0, y_q};
    assign state    = state_q;
    assign ducking  = ducking_q;
    assign airborne = airborne_q;

endmodule

// File: tb/tb_dino_motion_controller.sv
// Scoreboard bench for dino_motion_controller: expected frame results are queued
// as each tick is driven and compared once the DUT has updated.
// Honours DINO_FAST_FALL_EN to select the airborne-down scenario.
module tb_dino_motion_controller;

    logic        clk = 1'b0;
    logic        reset, screenEnd, up, down;
    logic [31:0] dino_x, dino_y;
    logic        ducking, airborne;
    logic [1:0]  state;

    typedef struct packed {
        logic [1:0] st;
        logic [9:0] y;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    dino_motion_controller dut (
        .clk       (clk),
        .reset     (reset),
        .screenEnd (screenEnd),
        .up        (up),
        .down      (down),
        .dino_x    (dino_x),
        .dino_y    (dino_y),
        .ducking   (ducking),
        .airborne  (airborne),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] st, input int y);
        exp_t e;
        e.st = st;
        e.y  = 10'(y);
        return e;
    endfunction

    // Closed-form jump trajectory: k-th tick after take-off.
    function automatic exp_t jump_exp(input int k);
        int y;
        int m;
        if (k <= 14) begin
            y = 275 - (14 * k - (k * (k - 1)) / 2);
            return mk((k < 14) ? 2'd1 : 2'd2, y);
        end
        m = k - 14;
        y = 170 + (m * (m + 1)) / 2;
        if (y >= 275) return mk(2'd0, 275);
        return mk(2'd2, y);
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        check_val({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val({tag, "_state"}, {30'd0, state}, {30'd0, e.st});
            check_val({tag, "_y"}, dino_y, {22'd0, e.y});
            check_val({tag, "_ducking"}, {31'd0, ducking}, {31'd0, (e.st == 2'd3)});
            check_val({tag, "_airborne"}, {31'd0, airborne},
                      {31'd0, (e.st == 2'd1) || (e.st == 2'd2)});
        end
    endtask

    task automatic frame(input exp_t e, input int hold, input string tag);
        sb_q.push_back(e);
        @(negedge clk) screenEnd = 1'b1;
        repeat (hold) @(negedge clk);
        screenEnd = 1'b0;
        repeat (3) @(negedge clk);
        compare_out(tag);
    endtask

    task automatic press_up();
        @(negedge clk) up = 1'b1;
        repeat (4) @(negedge clk);
        up = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        screenEnd = 1'b0;
        up = 1'b0;
        down = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_state", {30'd0, state}, 32'd0);
        check_val("rst_y", dino_y, 32'd275);
        check_val("rst_x", dino_x, 32'd100);
        check_val("rst_ducking", {31'd0, ducking}, 32'd0);
        check_val("rst_airborne", {31'd0, airborne}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Button activity without any frame boundary must not move the sprite.
        press_up();
        press_up();
        repeat (20) @(negedge clk);
        check_val("frozen_y", dino_y, 32'd275);
        check_val("frozen_state", {30'd0, state}, 32'd0);

        // Full jump from the pending press; screenEnd held 1..4 clocks.
        for (int k = 1; k <= 28; k++) frame(jump_exp(k), (k % 4) + 1, $sformatf("jump%0d", k));
        frame(mk(2'd0, 275), 4, "post_land");

        // Ducking, with an up press that must be ignored.
        down = 1'b1;
        settle();
        frame(mk(2'd3, 275), 2, "duck");
        press_up();
        frame(mk(2'd3, 275), 2, "duck_up");
        down = 1'b0;
        settle();
        frame(mk(2'd0, 275), 2, "unduck");
        frame(mk(2'd0, 275), 2, "no_late_jump");

        // Jump beats duck when both are present at the tick.
        @(negedge clk);
        up = 1'b1;
        down = 1'b1;
        repeat (4) @(negedge clk);
        up = 1'b0;
        settle();
        frame(jump_exp(1), 1, "both_k1");
        down = 1'b0;
        settle();
        for (int k = 2; k <= 20; k++) frame(jump_exp(k), 2, $sformatf("both_k%0d", k));

        // Asynchronous reset in the middle of the fall.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("rst_fall_y", dino_y, 32'd275);
        check_val("rst_fall_state", {30'd0, state}, 32'd0);
        check_val("rst_fall_ducking", {31'd0, ducking}, 32'd0);
        check_val("rst_fall_airborne", {31'd0, airborne}, 32'd0);
        check_val("rst_fall_x", dino_x, 32'd100);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Down pressed during the rise at tick 5.
        press_up();
        for (int k = 1; k <= 4; k++) frame(jump_exp(k), 2, $sformatf("dair_k%0d", k));
        down = 1'b1;
        settle();
`ifdef DINO_FAST_FALL_EN
        frame(mk(2'd2, 225), 2, "ff_t5");
        frame(mk(2'd2, 241), 2, "ff_t6");
        frame(mk(2'd2, 257), 2, "ff_t7");
        frame(mk(2'd2, 273), 2, "ff_t8");
        frame(mk(2'd0, 275), 2, "ff_land");
        down = 1'b0;
        settle();
        frame(mk(2'd0, 275), 2, "ff_after");
`else
        for (int k = 5; k <= 20; k++) frame(jump_exp(k), 2, $sformatf("dair_k%0d", k));
        down = 1'b0;
        settle();
        for (int k = 21; k <= 28; k++) frame(jump_exp(k), 2, $sformatf("dair_k%0d", k));
`endif

        check_val("sb_drained", sb_q.size(), 0);
        check_val("final_x", dino_x, 32'd100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
